// File: rtl/sdram_pkg.sv
// Shared types and helpers for the SDRAM CPU-side bridge.
// State encoding, controller timing and byte-lane helpers.
package sdram_pkg;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    RD_WAIT,
    WR_WAIT,
    DRAIN
  } state_t;

  localparam int FRAME_CLK   = 16;
  localparam int REFRESH_CNT = 31;

  function automatic logic [3:0] dqm_of(
    input logic [3:0] strb
  );
    return ~strb;
  endfunction

  function automatic logic [31:0] merge_bytes(
    input logic [31:0] old_w,
    input logic [31:0] new_w,
    input logic [3:0]  strb
  );
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++)
      if (strb[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/sdram_bus_bridge.sv
// CPU valid/ready port to SDRAM controller oe/we bridge with
// init sequencing, a posted-write buffer and a one-word read cache.
module sdram_bus_bridge
  import sdram_pkg::*;
#(
  parameter int AW         = 26,
  parameter int INIT_WAIT  = 600,
  parameter int INIT_PULSE = 4,
  parameter int READ_CACHE = 1
) (
  input  logic          clk,
  input  logic          resetq,
  input  logic          mem_valid,
  input  logic [AW-1:0] mem_addr,
  input  logic [3:0]    mem_wstrb,
  input  logic [31:0]   mem_wdata,
  output logic          mem_ready,
  output logic [31:0]   mem_rdata,
  output logic          sd_init,
  output logic [AW-1:0] sd_addr,
  output logic          sd_we,
  output logic          sd_oe,
  output logic [3:0]    sd_dqm,
  output logic [31:0]   sd_din,
  input  logic [31:0]   sd_dout,
  input  logic          sd_ready
);

  localparam int CW = $clog2(INIT_WAIT + 1);
  localparam int TW = AW - 2;

  state_t          r_state, r_state_n;
  logic [CW-1:0]   r_cnt, r_cnt_n;
  logic            r_init, r_init_n;
  logic [AW-1:0]   r_addr, r_addr_n;
  logic            r_we, r_we_n;
  logic            r_oe, r_oe_n;
  logic [3:0]      r_dqm, r_dqm_n;
  logic [31:0]     r_din, r_din_n;
  logic            r_ready, r_ready_n;
  logic [31:0]     r_rdata, r_rdata_n;
  logic            r_rdy_q;
  logic            r_wb_vld, r_wb_vld_n;
  logic [TW-1:0]   r_wb_addr, r_wb_addr_n;
  logic [31:0]     r_wb_data, r_wb_data_n;
  logic [3:0]      r_wb_strb, r_wb_strb_n;
  logic            r_c_vld, r_c_vld_n;
  logic [TW-1:0]   r_c_tag, r_c_tag_n;
  logic [31:0]     r_c_data, r_c_data_n;

  logic            w_rdy_rise;
  logic [TW-1:0]   w_tag;
  logic            w_hit;
  logic            w_req;
  logic            w_unused;

  assign w_unused   = &{1'b0, mem_addr[1:0]};
  assign w_rdy_rise = sd_ready & ~r_rdy_q;
  assign w_tag      = mem_addr[AW-1:2];
  assign w_hit      = (READ_CACHE != 0) && r_c_vld
                      && (r_c_tag == w_tag);
  // r_ready blocks re-accepting the request being acknowledged
  assign w_req      = mem_valid && !r_ready;

  always_comb begin
    r_state_n   = r_state;
    r_cnt_n     = r_cnt;
    r_init_n    = 1'b0;
    r_addr_n    = r_addr;
    r_we_n      = r_we;
    r_oe_n      = r_oe;
    r_dqm_n     = r_dqm;
    r_din_n     = r_din;
    r_ready_n   = 1'b0;
    r_rdata_n   = r_rdata;
    r_wb_vld_n  = r_wb_vld;
    r_wb_addr_n = r_wb_addr;
    r_wb_data_n = r_wb_data;
    r_wb_strb_n = r_wb_strb;
    r_c_vld_n   = r_c_vld;
    r_c_tag_n   = r_c_tag;
    r_c_data_n  = r_c_data;
    unique case (r_state)
      INIT: begin
        r_cnt_n  = r_cnt + 1'b1;
        r_init_n = (r_cnt < CW'(INIT_PULSE));
        if (r_cnt == CW'(INIT_WAIT - 1)) begin
          r_state_n = IDLE;
          r_init_n  = 1'b0;
        end
      end
      IDLE: begin
        if (r_wb_vld) begin
          r_addr_n  = {r_wb_addr, 2'b00};
          r_din_n   = r_wb_data;
          r_dqm_n   = dqm_of(r_wb_strb);
          r_we_n    = 1'b1;
          r_state_n = WR_WAIT;
        end else if (w_req && (mem_wstrb != 4'b0000)) begin
          r_wb_vld_n  = 1'b1;
          r_wb_addr_n = w_tag;
          r_wb_data_n = mem_wdata;
          r_wb_strb_n = mem_wstrb;
          r_ready_n   = 1'b1;
          if (w_hit)
            r_c_data_n = merge_bytes(r_c_data, mem_wdata,
                                     mem_wstrb);
        end else if (w_req && w_hit) begin
          r_ready_n = 1'b1;
          r_rdata_n = r_c_data;
        end else if (w_req) begin
          r_addr_n  = {w_tag, 2'b00};
          r_dqm_n   = 4'b0000;
          r_oe_n    = 1'b1;
          r_state_n = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (w_rdy_rise) begin
          r_oe_n     = 1'b0;
          r_rdata_n  = sd_dout;
          r_c_vld_n  = 1'b1;
          r_c_tag_n  = r_addr[AW-1:2];
          r_c_data_n = sd_dout;
          r_ready_n  = 1'b1;
          r_state_n  = DRAIN;
        end
      end
      WR_WAIT: begin
        if (w_rdy_rise) begin
          r_we_n     = 1'b0;
          r_wb_vld_n = 1'b0;
          r_state_n  = DRAIN;
        end
      end
      DRAIN: begin
        if (!sd_ready) r_state_n = IDLE;
      end
      default: r_state_n = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_state   <= INIT;
      r_cnt     <= '0;
      r_init    <= 1'b0;
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_oe      <= 1'b0;
      r_dqm     <= 4'b0000;
      r_din     <= '0;
      r_ready   <= 1'b0;
      r_rdata   <= '0;
      r_rdy_q   <= 1'b0;
      r_wb_vld  <= 1'b0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
      r_wb_strb <= 4'b0000;
      r_c_vld   <= 1'b0;
      r_c_tag   <= '0;
      r_c_data  <= '0;
    end else begin
      r_state   <= r_state_n;
      r_cnt     <= r_cnt_n;
      r_init    <= r_init_n;
      r_addr    <= r_addr_n;
      r_we      <= r_we_n;
      r_oe      <= r_oe_n;
      r_dqm     <= r_dqm_n;
      r_din     <= r_din_n;
      r_ready   <= r_ready_n;
      r_rdata   <= r_rdata_n;
      r_rdy_q   <= sd_ready;
      r_wb_vld  <= r_wb_vld_n;
      r_wb_addr <= r_wb_addr_n;
      r_wb_data <= r_wb_data_n;
      r_wb_strb <= r_wb_strb_n;
      r_c_vld   <= r_c_vld_n;
      r_c_tag   <= r_c_tag_n;
      r_c_data  <= r_c_data_n;
    end
  end

  assign mem_ready = r_ready;
  assign mem_rdata = r_rdata;
  assign sd_init   = r_init;
  assign sd_addr   = r_addr;
  assign sd_we     = r_we;
  assign sd_oe     = r_oe;
  assign sd_dqm    = r_dqm;
  assign sd_din    = r_din;

endmodule

// File: tb/tb_sdram_bus_bridge.sv
// Directed bench for sdram_bus_bridge with a behavioural
// SDRAM controller model (ready after 10-16 clk, held 2 clk).
module tb_sdram_bus_bridge;

  localparam int AW = 26;

  logic          clk = 1'b0;
  logic          resetq;
  logic          mem_valid;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_wstrb;
  logic [31:0]   mem_wdata;
  logic          mem_ready;
  logic [31:0]   mem_rdata;
  logic          sd_init;
  logic [AW-1:0] sd_addr;
  logic          sd_we;
  logic          sd_oe;
  logic [3:0]    sd_dqm;
  logic [31:0]   sd_din;
  logic [31:0]   sd_dout;
  logic          sd_ready;

  int n_chk  = 0;
  int n_fail = 0;

  sdram_bus_bridge #(
    .AW(AW), .INIT_WAIT(600), .INIT_PULSE(4), .READ_CACHE(1)
  ) dut (
    .clk(clk), .resetq(resetq),
    .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .sd_init(sd_init), .sd_addr(sd_addr),
    .sd_we(sd_we), .sd_oe(sd_oe), .sd_dqm(sd_dqm),
    .sd_din(sd_din), .sd_dout(sd_dout),
    .sd_ready(sd_ready)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [logic [23:0]];

  // controller model
  initial begin
    logic [23:0] k;
    logic        w;
    int          dly;
    sd_ready = 1'b0;
    sd_dout  = '0;
    mem[24'h000040] = 32'hDEADBEEF;
    mem[24'h000080] = 32'h0BADF00D;
    mem[24'h0000C0] = 32'hCAFE0001;
    forever begin
      @(posedge clk); #1;
      if (resetq && (sd_oe || sd_we)) begin
        k   = sd_addr[AW-1:2];
        w   = sd_we;
        dly = $urandom_range(16, 10);
        repeat (dly - 1) @(posedge clk);
        #1;
        if (!mem.exists(k)) mem[k] = '0;
        if (w) begin
          for (int i = 0; i < 4; i++)
            if (!sd_dqm[i]) mem[k][8*i +: 8] = sd_din[8*i +: 8];
        end else begin
          sd_dout = mem[k];
        end
        sd_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 sd_ready = 1'b0;
      end
    end
  end

  // bus monitor
  int          cyc = 0, n_init = 0, n_oe = 0, n_we = 0;
  int          n_both = 0, n_unstable = 0;
  int          oe_cyc = 0, we_done_cyc = 0;
  logic        oe_q = 1'b0, we_q = 1'b0;
  logic [3:0]  we_dqm = '0;
  logic [AW-1:0] we_addr = '0;
  logic [31:0] we_din = '0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    oe_q <= sd_oe;
    we_q <= sd_we;
    if (sd_init) n_init <= n_init + 1;
    if (sd_oe && !oe_q) begin
      n_oe   <= n_oe + 1;
      oe_cyc <= cyc;
    end
    if (sd_we && !we_q) begin
      n_we    <= n_we + 1;
      we_dqm  <= sd_dqm;
      we_addr <= sd_addr;
      we_din  <= sd_din;
    end
    if (sd_we && we_q &&
        (sd_dqm != we_dqm || sd_addr != we_addr || sd_din != we_din))
      n_unstable <= n_unstable + 1;
    if (sd_we && sd_oe) n_both <= n_both + 1;
    if (sd_we && sd_ready) we_done_cyc <= cyc;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cpu(input logic [AW-1:0] a, input logic [3:0] s,
                     input logic [31:0] d, output logic [31:0] rd,
                     output int lat);
    @(posedge clk); #1;
    mem_valid = 1'b1;
    mem_addr  = a;
    mem_wstrb = s;
    mem_wdata = d;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!mem_ready && lat < 1000);
    if (!mem_ready) chk("cpu_timeout", mem_ready, 1'b1);
    rd = mem_rdata;
    mem_valid = 1'b0;
    mem_wstrb = 4'b0000;
  endtask

  initial begin
    logic [31:0] rd;
    int lat, c0, i0, o0, w0;
    resetq    = 1'b0;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wstrb = 4'b0000;
    mem_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", mem_ready, 1'b0);
    chk("rst_rdata", mem_rdata, 32'h0);
    chk("rst_req", {sd_init, sd_oe, sd_we}, 3'b000);
    chk("rst_addr", {sd_addr, sd_dqm}, '0);
    chk("rst_din", sd_din, 32'h0);

    // release; a read presented during INIT is held off
    @(posedge clk); #1;
    resetq = 1'b1;
    c0 = cyc; i0 = n_init; o0 = n_oe;
    cpu(26'h000100, 4'b0000, 32'h0, rd, lat);
    chk("init_pulse", n_init - i0, 4);
    chk("init_hold", (oe_cyc - c0) >= 600, 1'b1);
    chk("rd_miss_data", rd, 32'hDEADBEEF);
    chk("rd_miss_oe", n_oe - o0, 1);

    // cache hit
    repeat (5) @(posedge clk);
    o0 = n_oe;
    cpu(26'h000100, 4'b0000, 32'h0, rd, lat);
    chk("hit_lat", lat, 1);
    chk("hit_data", rd, 32'hDEADBEEF);
    chk("hit_no_oe", n_oe - o0, 0);

    // posted byte write into the cached word
    w0 = n_we;
    cpu(26'h000100, 4'b0010, 32'h0000AA00, rd, lat);
    chk("wr_lat", lat, 1);
    for (int i = 0; i < 50 && !sd_we; i++) @(posedge clk);
    for (int i = 0; i < 50 && sd_we; i++) @(posedge clk);
    repeat (5) @(posedge clk);
    chk("wr_issued", n_we - w0, 1);
    chk("wr_dqm", we_dqm, 4'b1101);
    chk("wr_addr", we_addr, 26'h000100);
    chk("wr_din", we_din, 32'h0000AA00);
    chk("wr_mem", mem[24'h000040], 32'hDEADAAEF);
    o0 = n_oe;
    cpu(26'h000100, 4'b0000, 32'h0, rd, lat);
    chk("merge_lat", lat, 1);
    chk("merge_data", rd, 32'hDEADAAEF);
    chk("merge_no_oe", n_oe - o0, 0);

    // write then immediate read of another word
    repeat (3) @(posedge clk);
    cpu(26'h000200, 4'b1111, 32'h11223344, rd, lat);
    chk("wr2_lat", lat, 1);
    cpu(26'h000200, 4'b0000, 32'h0, rd, lat);
    chk("rd_after_wr", rd, 32'h11223344);
    chk("rd_stalled", oe_cyc > we_done_cyc, 1'b1);
    chk("we_oe_excl", n_both, 0);
    chk("wr_stable", n_unstable, 0);

    // reset while a read is in RD_WAIT
    repeat (5) @(posedge clk); #1;
    mem_valid = 1'b1;
    mem_addr  = 26'h000300;
    mem_wstrb = 4'b0000;
    for (int i = 0; i < 50 && !sd_oe; i++) begin
      @(posedge clk); #1;
    end
    chk("rst_oe_seen", sd_oe, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetq = 1'b0;
    #1;
    chk("rst_oe_drop", sd_oe, 1'b0);
    chk("rst_mid_ready", mem_ready, 1'b0);
    mem_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    resetq = 1'b1;
    i0 = n_init; o0 = n_oe; w0 = n_we;
    repeat (600) @(posedge clk);
    #1;
    chk("reinit_pulse", n_init - i0, 4);
    chk("reinit_quiet", (n_oe - o0) + (n_we - w0), 0);
    repeat (5) @(posedge clk);
    o0 = n_oe;
    cpu(26'h000100, 4'b0000, 32'h0, rd, lat);
    chk("post_rst_data", rd, 32'hDEADAAEF);
    chk("post_rst_miss", n_oe - o0, 1);
    chk("post_rst_lat", lat <= 32, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
